// File: rtl/gain_ramp_mc.sv
// Multi-channel fractional gain stage with per-sample linear gain ramping,
// round-half-up and saturation on a time-multiplexed sample stream.
module gain_ramp_mc #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 8,
  parameter int FRAC_W    = 6,
  parameter int N_CH      = 2,
  parameter int RAMP_STEP = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [$clog2(N_CH)-1:0]   in_ch,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      gain_wr,
  input  logic [$clog2(N_CH)-1:0]   gain_wr_ch,
  input  logic [GAIN_W-1:0]         gain_wr_data,
  input  logic                      bypass,
  output logic                      out_valid,
  output logic [$clog2(N_CH)-1:0]   out_ch,
  output logic signed [DATA_W-1:0]  out_data,
  output logic                      sat_flag,
  output logic                      ramp_busy
);
  localparam int CH_W   = $clog2(N_CH);
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << FRAC_W);
  localparam logic [GAIN_W-1:0] STEP  = GAIN_W'(RAMP_STEP);
  localparam logic [CH_W:0]     NCH   = (CH_W+1)'(N_CH);
  localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1) <<< (FRAC_W - 1);
  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic signed [PROD_W-1:0] round_half_up(input logic signed [PROD_W-1:0] p);
    return (p + HALF) >>> FRAC_W;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [DATA_W:0] saturate(input logic signed [PROD_W-1:0] r);
    if (r > PROD_W'(DMAX)) return {1'b1, DMAX};
    if (r < PROD_W'(DMIN)) return {1'b1, DMIN};
    return {1'b0, r[DATA_W-1:0]};
  endfunction

  function automatic logic [GAIN_W-1:0] ramp_step(input logic [GAIN_W-1:0] cur,
                                                  input logic [GAIN_W-1:0] tgt);
    if (cur < tgt) return ((tgt - cur) < STEP) ? tgt : cur + STEP;
    if (cur > tgt) return ((cur - tgt) < STEP) ? tgt : cur - STEP;
    return cur;
  endfunction

  logic [GAIN_W-1:0] r_cur_gain [N_CH];
  logic [GAIN_W-1:0] r_tgt_gain [N_CH];
  logic [GAIN_W-1:0] w_cur_nxt  [N_CH];
  logic [GAIN_W-1:0] w_tgt_nxt  [N_CH];
  logic              w_busy_nxt;
  logic              w_accept;
  logic              w_wr_ok;
  logic [GAIN_W-1:0] w_gain;
  logic signed [PROD_W-1:0] w_prod;

  assign w_accept = in_valid && ({1'b0, in_ch} < NCH);
  assign w_wr_ok  = gain_wr && ({1'b0, gain_wr_ch} < NCH);
  assign w_gain   = r_cur_gain[in_ch];
  assign w_prod   = PROD_W'(in_data) * PROD_W'($signed({1'b0, w_gain}));

  // The step uses the pre-write target; a same-cycle write only affects later steps.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_cur_nxt[c] = r_cur_gain[c];
      w_tgt_nxt[c] = r_tgt_gain[c];
    end
    if (w_accept && !bypass)
      w_cur_nxt[in_ch] = ramp_step(r_cur_gain[in_ch], r_tgt_gain[in_ch]);
    if (w_wr_ok)
      w_tgt_nxt[gain_wr_ch] = gain_wr_data;
    w_busy_nxt = 1'b0;
    for (int c = 0; c < N_CH; c++)
      w_busy_nxt = w_busy_nxt | (w_cur_nxt[c] != w_tgt_nxt[c]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        r_cur_gain[c] <= UNITY;
        r_tgt_gain[c] <= UNITY;
      end
      ramp_busy <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        r_cur_gain[c] <= w_cur_nxt[c];
        r_tgt_gain[c] <= w_tgt_nxt[c];
      end
      ramp_busy <= w_busy_nxt;
    end
  end

  // Stage 1: product, channel, bypass and raw sample
  logic                     r_vld_p1;
  logic [CH_W-1:0]          r_ch_p1;
  logic                     r_byp_p1;
  logic signed [DATA_W-1:0] r_data_p1;
  logic signed [PROD_W-1:0] r_prod_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_ch_p1  <= '0;
      r_byp_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept;
      r_ch_p1  <= in_ch;
      r_byp_p1 <= bypass;
    end
  end

  always_ff @(posedge clk) begin
    r_data_p1 <= in_data;
    r_prod_p1 <= w_prod;
  end

  // Stage 2: round, saturate or bypass
  logic signed [PROD_W-1:0] w_round_p2;
  logic [DATA_W:0]          w_sat_p2;

  assign w_round_p2 = round_half_up(r_prod_p1);
  assign w_sat_p2   = saturate(w_round_p2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= r_vld_p1;
      if (r_vld_p1) begin
        out_ch <= r_ch_p1;
        if (r_byp_p1) begin
          out_data <= r_data_p1;
          sat_flag <= 1'b0;
        end else begin
          out_data <= w_sat_p2[DATA_W-1:0];
          sat_flag <= w_sat_p2[DATA_W];
        end
      end
    end
  end
endmodule

// File: tb/tb_gain_ramp_mc.sv
// Scoreboard bench for gain_ramp_mc: directed scenarios plus random traffic
// checked against an arithmetic reference model of gain, ramp and rounding.
module tb_gain_ramp_mc;
  localparam int DATA_W = 16;
  localparam int GAIN_W = 8;
  localparam int FRAC_W = 6;
  localparam int N_CH   = 2;
  localparam int STEP   = 1;
  localparam int CH_W   = $clog2(N_CH);
  localparam int UNITY  = 1 << FRAC_W;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic                     gain_wr;
  logic [CH_W-1:0]          gain_wr_ch;
  logic [GAIN_W-1:0]        gain_wr_data;
  logic                     bypass;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [DATA_W-1:0] out_data;
  logic                     sat_flag;
  logic                     ramp_busy;

  gain_ramp_mc #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .FRAC_W(FRAC_W),
                 .N_CH(N_CH), .RAMP_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .gain_wr(gain_wr), .gain_wr_ch(gain_wr_ch),
    .gain_wr_data(gain_wr_data), .bypass(bypass), .out_valid(out_valid),
    .out_ch(out_ch), .out_data(out_data), .sat_flag(sat_flag),
    .ramp_busy(ramp_busy));

  typedef struct {
    int ch;
    int data;
    int sat;
    int due;
  } exp_t;

  exp_t q[$];
  int   cur [N_CH];
  int   tgt [N_CH];
  int   exp_busy;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Gain applied with round-half-up division by 2^FRAC_W, then clipped.
  task automatic ref_scale(input int x, input int g, output int r, output int s);
    int n;
    int d;
    d = 1 << FRAC_W;
    n = x * g + d / 2;
    if (n >= 0) r = n / d;
    else        r = -((-n + d - 1) / d);
    s = 0;
    if (r > 32767)  begin r = 32767;  s = 1; end
    if (r < -32768) begin r = -32768; s = 1; end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      cur[c] = UNITY;
      tgt[c] = UNITY;
    end
    exp_busy = 0;
    q.delete();
  endtask

  task automatic step(input bit v, input int ch, input int d, input bit wr,
                      input int wch, input int wd, input bit byp);
    exp_t e;
    int   r;
    int   s;
    in_valid     = v;
    in_ch        = CH_W'(ch);
    in_data      = DATA_W'(d);
    gain_wr      = wr;
    gain_wr_ch   = CH_W'(wch);
    gain_wr_data = GAIN_W'(wd);
    bypass       = byp;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (v && ch < N_CH) begin
        if (byp) begin
          r = d;
          s = 0;
        end else begin
          ref_scale(d, cur[ch], r, s);
        end
        e.ch = ch; e.data = r; e.sat = s; e.due = cyc + 1;
        q.push_back(e);
        if (!byp) begin
          if (cur[ch] < tgt[ch])      cur[ch] += (tgt[ch] - cur[ch] < STEP) ? tgt[ch] - cur[ch] : STEP;
          else if (cur[ch] > tgt[ch]) cur[ch] -= (cur[ch] - tgt[ch] < STEP) ? cur[ch] - tgt[ch] : STEP;
        end
      end
      if (wr && wch < N_CH) tgt[wch] = wd;
      exp_busy = 0;
      for (int c = 0; c < N_CH; c++) if (cur[c] != tgt[c]) exp_busy = 1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sample(input int ch, input int d);
    step(1, ch, d, 0, 0, 0, 0);
  endtask

  task automatic write(input int ch, input int g);
    step(0, 0, 0, 1, ch, g, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_out_valid", int'(out_valid), 0);
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("latency", cyc, e.due);
          check("out_ch", int'(out_ch), e.ch);
          check("out_data", int'(out_data), e.data);
          check("sat_flag", int'(sat_flag), e.sat);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        check("missing_out_valid", 0, 1);
        void'(q.pop_front());
      end
      check("ramp_busy", int'(ramp_busy), exp_busy);
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_n = 1'b0;
    model_reset();
    idle(3);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_ramp_busy", int'(ramp_busy), 0);
    rst_n = 1'b1;
    idle(2);

    // Unity gain after reset.
    sample(0, 1000);
    idle(3);

    // Ramp ch0 up to 2x while ch1 stays at unity.
    write(0, 128);
    for (int i = 0; i < 70; i++) begin
      sample(0, 1000);
      sample(1, 500);
    end
    idle(3);

    // Saturation at gain 255.
    write(0, 255);
    for (int i = 0; i < 130; i++) sample(0, int'($urandom_range(0, 200)) - 100);
    sample(0, 20000);
    sample(0, -20000);
    sample(0, 100);
    sample(0, 32767);
    sample(0, -32768);
    idle(3);

    // Rounding at gain 96.
    write(1, 96);
    for (int i = 0; i < 40; i++) sample(1, int'($urandom_range(0, 20)) - 10);
    sample(1, 3);
    sample(1, -3);
    sample(1, -1);
    sample(1, 1);
    idle(3);

    // Same-cycle write and sample, then ramp down to zero.
    write(0, 64);
    for (int i = 0; i < 200; i++) sample(0, 1000);
    step(1, 0, 1000, 1, 0, 0, 0);
    for (int i = 0; i < 66; i++) sample(0, 1000);
    idle(2);

    // Bypass freezes the ramp while still accepting gain writes.
    write(0, 128);
    for (int i = 0; i < 10; i++) sample(0, 700);
    for (int i = 0; i < 10; i++) step(1, 0, int'($urandom_range(0, 65535)) - 32768, 0, 0, 0, 1);
    step(1, 1, -1234, 1, 0, 20, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 700, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) sample(0, 700);
    idle(3);

    // Asynchronous reset with two samples in flight mid-ramp.
    write(1, 200);
    sample(1, 1000);
    sample(0, 1000);
    sample(1, 1000);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_out_valid", int'(out_valid), 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    sample(0, 1234);
    sample(1, 1234);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), int'($urandom_range(0, N_CH - 1)),
           int'($urandom_range(0, 65535)) - 32768,
           ($urandom_range(0, 19) == 0), int'($urandom_range(0, N_CH - 1)),
           int'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));
    end
    idle(4);
    check("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gain_ramp_mc.md
Name: gain_ramp_mc

Overview:
Multi-channel, parametrised programmable gain stage for the audio equalizer band paths. It replaces fixed shift-based gain selection with a fractional per-channel gain coefficient. Gain changes are ramped linearly per sample to avoid zipper noise. Results are rounded and saturated, and the block sits between each band filter and the band summer on a time-multiplexed sample stream.

Parameters:
DATA_W, 16, sample width (signed two's complement)
GAIN_W, 8, coefficient width (unsigned)
FRAC_W, 6, fractional bits of coefficient; unity = 1<<FRAC_W; FRAC_W >= 1
N_CH, 2, number of interleaved channels/bands; N_CH >= 2
RAMP_STEP, 1, coefficient LSBs moved per accepted sample of a channel

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample strobe
in_ch  in  $clog2(N_CH)  channel index of in_data
in_data  in  DATA_W  signed input sample
gain_wr  in  1  target-coefficient write strobe
gain_wr_ch  in  $clog2(N_CH)  channel being written
gain_wr_data  in  GAIN_W  new target coefficient
bypass  in  1  1 = pass samples unscaled and freeze ramps
out_valid  out  1  result strobe
out_ch  out  $clog2(N_CH)  channel index of out_data
out_data  out  DATA_W  signed scaled sample
sat_flag  out  1  out_data was clipped; qualified by out_valid
ramp_busy  out  1  OR over channels of (cur_gain != target_gain)

Behaviour:
- Per channel there are two registers: target_gain[c] and cur_gain[c]. Both reset to 1<<FRAC_W (unity).
- Reset values: out_valid=0, out_ch=0, out_data=0, sat_flag=0, ramp_busy=0. All pipeline valids clear.
- Reset is asynchronous. Asserting it mid-ramp or mid-pipeline discards in-flight samples and restores unity gain.
- No backpressure: a sample is accepted on every cycle with in_valid=1. Back-to-back samples are allowed, and any channel order is allowed.
- in_ch >= N_CH: the sample is dropped (no out_valid) and no state changes. A gain_wr to gain_wr_ch >= N_CH is ignored.
- Latency is fixed at 2 cycles: in_valid in cycle T gives out_valid in cycle T+2 with the same out_ch.
- Stage 1 registers prod = in_data * $signed({1'b0, cur_gain[in_ch]}), full width DATA_W+GAIN_W+1. It also registers ch, valid, and bypass/in_data.
- Stage 2:
  - Compute r = (prod + (1<<(FRAC_W-1))) >>> FRAC_W (round half toward +inf).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. sat_flag=1 iff clipped.
  - In bypass, out_data = the registered in_data and sat_flag=0.
- Ramp: each channel runs an implicit 3-state FSM: IDLE (cur==target), UP (cur<target), DOWN (cur>target).
  - The FSM advances only on an accepted, non-bypassed sample of that channel, after that sample has used the pre-update cur_gain.
  - UP: cur += min(RAMP_STEP, target-cur).
  - DOWN: cur -= min(RAMP_STEP, cur-target).
  - No overshoot and no wrap at 0 or 2^GAIN_W-1.
- Simultaneous gain_wr and sample on the same channel in the same cycle:
  - The sample uses the old cur_gain.
  - That cycle's ramp step moves toward the old target.
  - The new target governs steps from the next sample onward.
- A gain_wr during a ramp redirects the ramp from the current cur_gain. There is no jump.
- gain_wr is accepted while bypass=1. The ramp stays frozen until bypass=0.
- ramp_busy is registered. It reflects register state after the current cycle's updates.

Test Plan:
1. After reset: ch0, in_data=1000 -> out_data=1000 two cycles later, out_ch=0, sat_flag=0, ramp_busy=0.
2. gain_wr ch0=128, then 70 ch0 samples of 1000 interleaved with ch1 samples of 500:
   - ch0 outputs rise from 1000 by about 15.6 per sample.
   - The 65th ch0 sample onward gives 2000.
   - ramp_busy drops after the 64th ch0 sample.
   - ch1 stays 500 throughout.
3. Saturation with ch0 settled at gain 255:
   - in_data=20000 -> 32767, sat_flag=1.
   - in_data=-20000 -> -32768, sat_flag=1.
   - in_data=100 -> 398 (25500+32=25532, >>6 = 398), sat_flag=0.
4. Rounding with ch1 settled at gain 96:
   - in_data=3 -> 5.
   - in_data=-3 -> -4.
   - in_data=-1 -> -1 (-96+32=-64, >>6 = -1).
5. Same-cycle gain_wr ch0=0 and ch0 sample 1000 at cur=64:
   - Output is 1000 and cur stays 64.
   - The next ch0 sample gives 1000 and cur becomes 63.
   - After 64 further samples out_data=0.
   - Holding bypass=1 mid-ramp passes data unchanged and freezes cur.
6. Deassert rst_n for 1 cycle during the ramp with 2 samples in flight:
   - No out_valid is produced for those samples.
   - All cur_gain values return to 64.
   - The next sample 1234 -> 1234.
